div_share_ctrl: RTL and testbench

Shared-divider controller that lets `NREQ` requesters time-share one iterative restoring divider of width `WL`. It arbitrates round-robin among valid requests and sequences the divider through `WL` shift-subtract steps. It returns quotient and remainder to the granted requester with a one-cycle response strobe. It sits between the client blocks and the divider datapath and replaces per-client dividers.

---
 rtl/div_share_ctrl_pkg.sv | 20 ++
 rtl/div_rr_arbiter.sv | 54 +++++
 rtl/div_share_ctrl.sv | 129 ++++++++++++
 tb/tb_div_share_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_share_ctrl_pkg.sv
// Shared definitions for the time-shared restoring divider controller.
package div_share_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step-counter width for a WL-bit divide; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned wl);
    return (wl > 1) ? $clog2(wl) : 1;
  endfunction

  // Requester index width; at least one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index, pointer advances past each winner.
module div_rr_arbiter
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            upd_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  logic [IDW-1:0] cand_idx;
  int unsigned    cand;

  // Search from the pointer upward, wrapping modulo NREQ.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_q) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!found && req_i[cand_idx]) begin
        found          = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o          = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && found) begin
      ptr_d = (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + IDW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Controller letting NREQ clients time-share one WL-step restoring divider.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int unsigned WL   = 4,
  parameter int unsigned NREQ = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WL-1:0]   req_dividend,
  input  logic [NREQ*WL-1:0]   req_divisor,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WL-1:0]        quotient,
  output logic [WL-1:0]        remainder,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int unsigned IDW  = id_width(NREQ);
  localparam int unsigned CntW = cnt_width(WL);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WL-1:0]   dvd_q, dvd_d;
  logic [WL-1:0]   dsr_q, dsr_d;
  logic [WL-1:0]   rem_q, rem_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [WL-1:0]   quo_q, quo_d;
  logic [WL-1:0]   rmd_q, rmd_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win_idx;
  logic            hs;
  logic [WL:0]     shifted, trial;
  logic [WL-1:0]   rem_nxt, dvd_nxt;

  div_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (req_valid),
    .upd_i (state_q == StIdle),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  assign req_ready = (state_q == StIdle) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  // The kept remainder is always below 2^WL, so only the shifted/trial value needs WL+1 bits.
  always_comb begin
    shifted = {rem_q, dvd_q[WL-1]};
    trial   = shifted - {1'b0, dsr_q};
    rem_nxt = trial[WL] ? shifted[WL-1:0] : trial[WL-1:0];
    dvd_nxt = {dvd_q[WL-2:0], ~trial[WL]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    id_d    = id_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          dvd_d   = req_dividend[32'(win_idx)*WL +: WL];
          dsr_d   = req_divisor[32'(win_idx)*WL +: WL];
          id_d    = win_idx;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        rem_d = rem_nxt;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WL - 1)) begin
          quo_d   = dvd_nxt;
          rmd_d   = rem_nxt;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign rsp_valid   = (state_q == StDone) ? (NREQ'(1) << id_q) : '0;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = (state_q == StDone) && (dsr_q == '0);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed self-checking bench for div_share_ctrl (WL=4, NREQ=2).
module tb_div_share_ctrl;

  localparam int WL   = 4;
  localparam int NREQ = 2;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*WL-1:0]   req_dividend;
  logic [NREQ*WL-1:0]   req_divisor;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [WL-1:0]        quotient;
  logic [WL-1:0]        remainder;
  logic                 div_by_zero;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  div_share_ctrl #(
    .WL   (WL),
    .NREQ (NREQ)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check the grant in the current IDLE cycle, then take the handshake edge.
  task automatic issue(input string tag, input logic [1:0] exp_rdy);
    #1;
    chk({tag, "_ready"}, 8'(req_ready), 8'(exp_rdy));
    chk({tag, "_idle"}, 8'(busy), 8'd0);
    step();
  endtask

  // Called just after the handshake edge: WL ITER cycles, one DONE cycle, back to IDLE.
  task automatic finish(input string tag, input logic [1:0] exp_rsp, input logic [3:0] q,
                        input logic [3:0] r, input logic dbz);
    for (int k = 0; k < WL; k++) begin
      chk({tag, "_iter_busy"}, 8'(busy), 8'd1);
      chk({tag, "_iter_rsp"}, 8'(rsp_valid), 8'd0);
      chk({tag, "_iter_rdy"}, 8'(req_ready), 8'd0);
      step();
    end
    chk({tag, "_done_busy"}, 8'(busy), 8'd1);
    chk({tag, "_rsp"}, 8'(rsp_valid), 8'(exp_rsp));
    chk({tag, "_quo"}, 8'(quotient), 8'(q));
    chk({tag, "_rem"}, 8'(remainder), 8'(r));
    chk({tag, "_dbz"}, 8'(div_by_zero), 8'(dbz));
    step();
    chk({tag, "_post_busy"}, 8'(busy), 8'd0);
    chk({tag, "_post_rsp"}, 8'(rsp_valid), 8'd0);
    chk({tag, "_hold_quo"}, 8'(quotient), 8'(q));
    chk({tag, "_hold_rem"}, 8'(remainder), 8'(r));
  endtask

  initial begin
    RST          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    step();
    step();
    RST = 1'b0;
    step();

    chk("rst_ready", 8'(req_ready), 8'd0);
    chk("rst_rsp", 8'(rsp_valid), 8'd0);
    chk("rst_quo", 8'(quotient), 8'd0);
    chk("rst_rem", 8'(remainder), 8'd0);
    chk("rst_dbz", 8'(div_by_zero), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);

    // 13 / 2 on requester 0
    req_valid = 2'b01;
    req_dividend[3:0] = 4'd13;
    req_divisor[3:0]  = 4'd2;
    issue("basic", 2'b01);
    req_valid = 2'b00;
    finish("basic", 2'b01, 4'd6, 4'd1, 1'b0);

    // 9 / 0 on requester 1
    req_valid = 2'b10;
    req_dividend[7:4] = 4'd9;
    req_divisor[7:4]  = 4'd0;
    issue("dbz", 2'b10);
    req_valid = 2'b00;
    finish("dbz", 2'b10, 4'hf, 4'd9, 1'b1);

    // Contention: pointer is 0 here, grants must alternate 0,1,0,1
    req_dividend = {4'd15, 4'd7};
    req_divisor  = {4'd4, 4'd3};
    req_valid    = 2'b11;
    issue("cont0a", 2'b01);
    finish("cont0a", 2'b01, 4'd2, 4'd1, 1'b0);
    issue("cont1a", 2'b10);
    finish("cont1a", 2'b10, 4'd3, 4'd3, 1'b0);
    issue("cont0b", 2'b01);
    finish("cont0b", 2'b01, 4'd2, 4'd1, 1'b0);
    issue("cont1b", 2'b10);
    finish("cont1b", 2'b10, 4'd3, 4'd3, 1'b0);
    req_valid = 2'b00;

    // Mid-op reset: grant 0 moves the pointer to 1, then reset in the third ITER cycle
    req_valid = 2'b01;
    issue("mrst", 2'b01);
    req_valid = 2'b00;
    step();
    step();
    chk("mrst_iter3_busy", 8'(busy), 8'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mrst_busy", 8'(busy), 8'd0);
    chk("mrst_rsp", 8'(rsp_valid), 8'd0);
    chk("mrst_quo", 8'(quotient), 8'd0);
    chk("mrst_rem", 8'(remainder), 8'd0);
    chk("mrst_dbz", 8'(div_by_zero), 8'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mrst_no_rsp", 8'(rsp_valid), 8'd0);
    end
    req_valid = 2'b11;
    issue("mrst_ptr", 2'b01);
    req_valid = 2'b00;
    finish("mrst_ptr", 2'b01, 4'd2, 4'd1, 1'b0);

    // Operand stability: inputs change right after the handshake
    req_valid = 2'b01;
    req_dividend[3:0] = 4'd12;
    req_divisor[3:0]  = 4'd5;
    issue("stab", 2'b01);
    req_valid = 2'b00;
    req_dividend[3:0] = 4'd1;
    req_divisor[3:0]  = 4'd1;
    finish("stab", 2'b01, 4'd2, 4'd2, 1'b0);

    // Edge values; pointer alternates so requester 0 alone still wins
    req_valid = 2'b01;
    req_dividend[3:0] = 4'd15;
    req_divisor[3:0]  = 4'd1;
    issue("e15_1", 2'b01);
    req_valid = 2'b00;
    finish("e15_1", 2'b01, 4'd15, 4'd0, 1'b0);

    req_valid = 2'b01;
    req_dividend[3:0] = 4'd0;
    req_divisor[3:0]  = 4'd7;
    issue("e0_7", 2'b01);
    req_valid = 2'b00;
    finish("e0_7", 2'b01, 4'd0, 4'd0, 1'b0);

    req_valid = 2'b01;
    req_dividend[3:0] = 4'd5;
    req_divisor[3:0]  = 4'd15;
    issue("e5_15", 2'b01);
    req_valid = 2'b00;
    finish("e5_15", 2'b01, 4'd0, 4'd5, 1'b0);

    step();
    chk("final_hold_rem", 8'(remainder), 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
